// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: turns clear/start/stop button levels into the
// armed -> random wait -> stimulus -> count -> result flow and tracks the best time.
module reaction_ctrl #(
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned MIN_WAIT_MS = 2000,
    parameter int unsigned WAIT_BITS   = 12,
    parameter int unsigned MAX_MS      = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        start,
    input  logic        stop,
    output logic        led,
    output logic [13:0] ms_count,
    output logic [1:0]  disp_mode,
    output logic [13:0] best_ms,
    output logic        best_valid,
    output logic        busy
);

    localparam int unsigned DivW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned WaitW   = 16;
    localparam logic [DivW-1:0]  DivLast = DivW'(TICK_DIV - 1);
    localparam logic [WaitW-1:0] MinWait = WaitW'(MIN_WAIT_MS);
    localparam logic [13:0]      MaxMs   = 14'(MAX_MS);

    typedef enum logic [2:0] {StIdle, StWait, StReact, StDone, StEarly, StTimeout} state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic              div_clr;
    logic [15:0]       lfsr_q;
    logic [WaitW-1:0]  wait_tgt_q, wait_tgt_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [13:0]       ms_q, ms_d;
    logic [13:0]       best_q, best_d;
    logic              best_valid_q, best_valid_d;
    logic              clear_q, start_q, stop_q;
    logic              clear_ev, start_ev, stop_ev, tick;

    assign clear_ev = clear & ~clear_q;
    assign start_ev = start & ~start_q;
    assign stop_ev  = stop & ~stop_q;
    assign tick     = (div_q == DivLast);
    assign div_d    = (div_clr || tick) ? '0 : div_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        ms_d         = ms_q;
        wait_tgt_d   = wait_tgt_q;
        wait_cnt_d   = wait_cnt_q;
        best_d       = best_q;
        best_valid_d = best_valid_q;
        div_clr      = 1'b0;
        if (clear_ev) begin
            state_d = StIdle;
            ms_d    = '0;
        end else begin
            case (state_q)
                StWait: begin
                    if (stop_ev) begin
                        state_d = StEarly;
                    end else if (tick) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                        if (wait_cnt_q + 1'b1 == wait_tgt_q) begin
                            state_d = StReact;
                            ms_d    = '0;
                            div_clr = 1'b1;
                        end
                    end
                end
                StReact: begin
                    // Stop beats a coincident tick, so the count freezes at its pre-edge value.
                    if (stop_ev) begin
                        state_d = StDone;
                        if (!best_valid_q || ms_q < best_q) begin
                            best_d       = ms_q;
                            best_valid_d = 1'b1;
                        end
                    end else if (tick) begin
                        ms_d = ms_q + 1'b1;
                        if (ms_q + 14'd1 == MaxMs) begin
                            state_d = StTimeout;
                        end
                    end
                end
                StIdle, StDone, StEarly, StTimeout: begin
                    if (start_ev) begin
                        state_d    = StWait;
                        wait_tgt_d = MinWait + WaitW'(lfsr_q[WAIT_BITS-1:0]);
                        wait_cnt_d = '0;
                        div_clr    = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        led       = 1'b0;
        busy      = 1'b0;
        disp_mode = 2'd0;
        case (state_q)
            StWait:    busy = 1'b1;
            StReact: begin
                led       = 1'b1;
                busy      = 1'b1;
                disp_mode = 2'd1;
            end
            StDone:    disp_mode = 2'd1;
            StEarly:   disp_mode = 2'd2;
            StTimeout: disp_mode = 2'd3;
            default:   disp_mode = 2'd0;
        endcase
    end

    assign ms_count   = ms_q;
    assign best_ms    = best_q;
    assign best_valid = best_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            div_q        <= '0;
            lfsr_q       <= 16'hACE1;
            wait_tgt_q   <= '0;
            wait_cnt_q   <= '0;
            ms_q         <= '0;
            best_q       <= 14'h3FFF;
            best_valid_q <= 1'b0;
            clear_q      <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            // Fibonacci taps 16,14,13,11
            lfsr_q       <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            wait_tgt_q   <= wait_tgt_d;
            wait_cnt_q   <= wait_cnt_d;
            ms_q         <= ms_d;
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            clear_q      <= clear;
            start_q      <= start;
            stop_q       <= stop;
        end
    end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with small timing parameters.
module tb_reaction_ctrl;

    logic        clk = 1'b0;
    logic        rst, clear, start, stop;
    logic        led, best_valid, busy;
    logic [13:0] ms_count, best_ms;
    logic [1:0]  disp_mode;

    always #5 clk = ~clk;

    reaction_ctrl #(
        .TICK_DIV(4),
        .MIN_WAIT_MS(2),
        .WAIT_BITS(2),
        .MAX_MS(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .start(start),
        .stop(stop),
        .led(led),
        .ms_count(ms_count),
        .disp_mode(disp_mode),
        .best_ms(best_ms),
        .best_valid(best_valid),
        .busy(busy)
    );

    // Reference LFSR, seeded and stepped like the design's random source.
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int n_checks = 0;
    int n_fails  = 0;
    int tgt      = 0;
    logic led_seen;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_attempt(input string tag);
        start = 1'b1;
        tgt   = 2 + int'(m_lfsr[1:0]);
        cyc(1);
        start = 1'b0;
        check({tag, "_busy"}, 16'(busy), 16'd1);
    endtask

    task automatic reach_react(input string tag);
        cyc(4 * tgt - 1);
        check({tag, "_led_pre"}, 16'(led), 16'd0);
        cyc(1);
        check({tag, "_led"}, 16'(led), 16'd1);
        check({tag, "_mode"}, 16'(disp_mode), 16'd1);
        check({tag, "_ms0"}, 16'(ms_count), 16'd0);
    endtask

    task automatic react_stop(input int k);
        cyc(4 * k);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_led"}, 16'(led), 16'd0);
        check({tag, "_ms"}, 16'(ms_count), 16'd0);
        check({tag, "_mode"}, 16'(disp_mode), 16'd0);
        check({tag, "_best"}, 16'(best_ms), 16'h3FFF);
        check({tag, "_bvalid"}, 16'(best_valid), 16'd0);
        check({tag, "_busy"}, 16'(busy), 16'd0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; start = 1'b0; stop = 1'b0;
        cyc(3);
        check_reset("reset");
        rst = 1'b0;

        // First attempt: stop after 28 cycles of REACT
        start_attempt("a1");
        reach_react("a1");
        react_stop(7);
        check("a1_mode", 16'(disp_mode), 16'd1);
        check("a1_ms", 16'(ms_count), 16'd7);
        check("a1_best", 16'(best_ms), 16'd7);
        check("a1_bvalid", 16'(best_valid), 16'd1);
        check("a1_led", 16'(led), 16'd0);
        check("a1_busy", 16'(busy), 16'd0);

        start_attempt("a2");
        check("a2_ms_held", 16'(ms_count), 16'd7);
        reach_react("a2");
        react_stop(9);
        check("a2_ms", 16'(ms_count), 16'd9);
        check("a2_best", 16'(best_ms), 16'd7);

        start_attempt("a3");
        reach_react("a3");
        react_stop(5);
        check("a3_ms", 16'(ms_count), 16'd5);
        check("a3_best", 16'(best_ms), 16'd5);

        // Early press
        start_attempt("early");
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("early_mode", 16'(disp_mode), 16'd2);
        check("early_busy", 16'(busy), 16'd0);
        check("early_ms", 16'(ms_count), 16'd5);
        led_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            led_seen = led_seen | led;
            cyc(1);
        end
        check("early_led_never", 16'(led_seen), 16'd0);
        check("early_best", 16'(best_ms), 16'd5);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        check("clr_mode", 16'(disp_mode), 16'd0);
        check("clr_ms", 16'(ms_count), 16'd0);
        check("clr_bvalid", 16'(best_valid), 16'd1);

        // Timeout
        start_attempt("to");
        reach_react("to");
        cyc(79);
        check("to_ms19", 16'(ms_count), 16'd19);
        check("to_mode_pre", 16'(disp_mode), 16'd1);
        cyc(1);
        check("to_ms", 16'(ms_count), 16'd20);
        check("to_mode", 16'(disp_mode), 16'd3);
        check("to_led", 16'(led), 16'd0);
        check("to_busy", 16'(busy), 16'd0);
        check("to_best", 16'(best_ms), 16'd5);

        // Stop coincident with the tick that would reach MAX_MS
        start_attempt("col");
        reach_react("col");
        cyc(79);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("col_mode", 16'(disp_mode), 16'd1);
        check("col_ms", 16'(ms_count), 16'd19);
        check("col_best", 16'(best_ms), 16'd5);

        // clear beats stop in the same REACT cycle
        start_attempt("cs");
        reach_react("cs");
        cyc(8);
        check("cs_ms2", 16'(ms_count), 16'd2);
        clear = 1'b1;
        stop  = 1'b1;
        cyc(1);
        clear = 1'b0;
        stop  = 1'b0;
        check("cs_mode", 16'(disp_mode), 16'd0);
        check("cs_ms", 16'(ms_count), 16'd0);
        check("cs_led", 16'(led), 16'd0);
        check("cs_busy", 16'(busy), 16'd0);
        check("cs_best", 16'(best_ms), 16'd5);

        // Held stop triggers EARLY once, then cannot abort the next attempt
        start_attempt("hold");
        stop = 1'b1;
        cyc(1);
        check("hold_early", 16'(disp_mode), 16'd2);
        cyc(5);
        check("hold_early_stays", 16'(disp_mode), 16'd2);
        start_attempt("hold2");
        reach_react("hold2");
        stop = 1'b0;
        cyc(5);
        check("hold2_still_react", 16'(led), 16'd1);

        // Reset mid-REACT
        rst = 1'b1;
        cyc(1);
        check_reset("rst_mid");
        rst = 1'b0;
        cyc(2);

        // LFSR rewound by reset: wait length follows the reseeded model
        start_attempt("post");
        reach_react("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
